// File: rtl/fifo_simple_dp_ram_pkg.sv
// Shared defaults and width helpers for the simple dual-port RAM FIFO.
package fifo_simple_dp_ram_pkg;

  localparam int DEFAULT_FIFO_DEPTH         = 32;
  localparam int DEFAULT_FIFO_DATA_WIDTH    = 8;
  localparam int DEFAULT_ALMOST_FULL_DEPTH  = 3;
  localparam int DEFAULT_ALMOST_EMPTY_DEPTH = 3;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module fifo_dp_ram
  import fifo_simple_dp_ram_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH  = DEFAULT_FIFO_DATA_WIDTH,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address write on this edge is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_simple_dp_ram.sv
// FIFO over a simple dual-port RAM with count-decoded flags.
// Optional sticky overflow/underflow outputs: define FIFO_SIMPLE_DP_RAM_ERR_EN.
module fifo_simple_dp_ram
  import fifo_simple_dp_ram_pkg::*;
#(
  parameter int FIFO_DEPTH         = DEFAULT_FIFO_DEPTH,
  parameter int FIFO_DATA_WIDTH    = DEFAULT_FIFO_DATA_WIDTH,
  parameter int ALMOST_FULL_DEPTH  = DEFAULT_ALMOST_FULL_DEPTH,
  parameter int ALMOST_EMPTY_DEPTH = DEFAULT_ALMOST_EMPTY_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [FIFO_DATA_WIDTH-1:0] write_data,
  output logic [FIFO_DATA_WIDTH-1:0] read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full
`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_accept;
  logic             rd_accept;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_DEPTH));
  assign almost_full  = (count_q >= CNT_W'(FIFO_DEPTH - ALMOST_FULL_DEPTH));

  // When full, a concurrent read frees the slot the write lands in.
  assign wr_accept = write && (!full || read);
  assign rd_accept = read && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_dp_ram #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FIFO_DATA_WIDTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (write_data),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (read_data)
  );

`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (write && !wr_accept);
    underflow_d = underflow_q || (read && !rd_accept);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_simple_dp_ram.sv
// Scoreboard bench for fifo_simple_dp_ram: stimulus pushes expected state, a monitor compares.
module tb_fifo_simple_dp_ram;

  localparam int DEPTH = 32;
  localparam int AE    = 3;
  localparam int AF    = 3;

  typedef struct {
    logic [7:0] rd;
    logic       empty;
    logic       full;
    logic       aempty;
    logic       afull;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] write_data = '0;
  logic [7:0] read_data;
  logic       empty, full, almost_empty, almost_full;
`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
  logic       overflow, underflow;
`endif

  int pass_count  = 0;
  int total_count = 0;

  exp_t       exp_q [$];
  logic [7:0] model_q [$];
  logic [7:0] model_rd  = '0;
  logic       model_ovf = 1'b0;
  logic       model_udf = 1'b0;

  fifo_simple_dp_ram dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .write_data   (write_data),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
`else
    .almost_full  (almost_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] d);
    exp_t e;
    logic m_full, m_empty;
    @(negedge clk);
    write = w;
    read = r;
    write_data = d;
    @(posedge clk);
    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    if (r && !m_empty) model_rd = model_q.pop_front();
    if (w && (!m_full || r)) model_q.push_back(d);
    if (w && m_full && !r) model_ovf = 1'b1;
    if (r && m_empty) model_udf = 1'b1;
    e.rd     = model_rd;
    e.empty  = (model_q.size() == 0);
    e.full   = (model_q.size() == DEPTH);
    e.aempty = (model_q.size() <= AE);
    e.afull  = (model_q.size() >= DEPTH - AF);
    e.ovf    = model_ovf;
    e.udf    = model_udf;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    write = 1'b0;
    read = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_value("rst_read_data", 32'(read_data), 0);
    check_value("rst_empty", 32'(empty), 1);
    check_value("rst_almost_empty", 32'(almost_empty), 1);
    check_value("rst_full", 32'(full), 0);
    check_value("rst_almost_full", 32'(almost_full), 0);
`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
    check_value("rst_overflow", 32'(overflow), 0);
    check_value("rst_underflow", 32'(underflow), 0);
`endif
    model_q.delete();
    model_rd  = '0;
    model_ovf = 1'b0;
    model_udf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e);
    end
  end

  task automatic check_output(input exp_t e);
    check_value("read_data", 32'(read_data), 32'(e.rd));
    check_value("empty", 32'(empty), 32'(e.empty));
    check_value("full", 32'(full), 32'(e.full));
    check_value("almost_empty", 32'(almost_empty), 32'(e.aempty));
    check_value("almost_full", 32'(almost_full), 32'(e.afull));
`ifdef FIFO_SIMPLE_DP_RAM_ERR_EN
    check_value("overflow", 32'(overflow), 32'(e.ovf));
    check_value("underflow", 32'(underflow), 32'(e.udf));
`endif
  endtask

  initial begin
    $display("[TB] start");
    apply_reset();

    // First pass: 40 spaced writes (32..39 dropped), 40 spaced reads.
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'(i));
      apply_stimulus(1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      apply_stimulus(1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    #1 check_value("pass1_last_read_data", 32'(read_data), 31);

    // Second pass across the pointer wrap.
    for (int i = 32; i < 72; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'(i));
      apply_stimulus(1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      apply_stimulus(1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    #1 check_value("pass2_last_read_data", 32'(read_data), 63);

    // Simultaneous write/read with five entries.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 8'(100 + i));
    apply_stimulus(1'b1, 1'b1, 8'd105);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 8'h00);

    // Simultaneous write/read when full.
    for (int i = 0; i < 32; i++) apply_stimulus(1'b1, 1'b0, 8'(200 + i));
    apply_stimulus(1'b1, 1'b1, 8'd240);
    for (int i = 0; i < 32; i++) apply_stimulus(1'b0, 1'b1, 8'h00);

    // Simultaneous write/read when empty: only the write lands.
    apply_stimulus(1'b1, 1'b1, 8'd50);
    apply_stimulus(1'b0, 1'b1, 8'h00);

    // Overflow and underflow, then sticky across normal traffic.
    for (int i = 0; i < 33; i++) apply_stimulus(1'b1, 1'b0, 8'(i + 1));
    for (int i = 0; i < 33; i++) apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'd9);
    apply_stimulus(1'b0, 1'b1, 8'h00);

    // Reset with ten entries stored, then a fresh write/read.
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 8'(150 + i));
    apply_reset();
    apply_stimulus(1'b1, 1'b0, 8'd77);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    @(negedge clk);
    @(negedge clk);
    check_value("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
